freq_gate_ctrl: RTL and testbench



---
 rtl/freq_meter_pkg.sv | 20 ++
 rtl/freq_gate_ctrl_sync_2ff.sv | 29 ++
 rtl/freq_gate_ctrl.sv | 166 ++++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency-meter gate controller.
// Holds the FSM state encoding, the BCD digit limit and the gate-length calculation.
package freq_meter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GATE   = 3'd1,
        SETTLE = 3'd2,
        LATCH  = 3'd3,
        CLEAR  = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Gate window length in clk cycles; divide first so large CLK_HZ cannot overflow int.
    function automatic int gate_cycles(input int clk_hz, input int gate_ms);
        return (clk_hz / 1000) * gate_ms;
    endfunction

endpackage

// File: rtl/freq_gate_ctrl_sync_2ff.sv
// Two-flop synchroniser for a single level signal; clears on synchronous reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate/clear sequencer for the BCD counter chain: times the gate window, waits for the
// counters to settle, latches count and flags into a held result, then clears the chain.
module freq_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int GATE_MS    = 1000,
    parameter int DIGITS     = 6,
    parameter int SETTLE_CYC = 4,
    parameter int CLEAR_CYC  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  ovf_in,
    output logic                  gate_en,
    output logic                  cnt_clear,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   result,
    output logic                  result_valid,
    output logic                  overflow,
    output logic                  bcd_err
);

    localparam int GATE_CYC = gate_cycles(CLK_HZ, GATE_MS);
    localparam int MAX_GS   = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
    localparam int MAX_CYC  = (MAX_GS > CLEAR_CYC) ? MAX_GS : CLEAR_CYC;
    localparam int TMR_W    = $clog2(MAX_CYC + 1);

    // The timer is loaded with N-1 on entry so a state lasts exactly N cycles.
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] CLEAR_LOAD  = TMR_W'(CLEAR_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

    if (GATE_CYC < 1) begin : g_bad_gate
        $error("freq_gate_ctrl: GATE_CYC evaluates to 0");
    end
    if (SETTLE_CYC < 1 || CLEAR_CYC < 1) begin : g_bad_phase
        $error("freq_gate_ctrl: SETTLE_CYC and CLEAR_CYC must be at least 1");
    end

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic                 gate_en_q, gate_en_d;
    logic                 cnt_clear_q, cnt_clear_d;
    logic                 busy_q, busy_d;
    logic [4*DIGITS-1:0]  result_q, result_d;
    logic                 result_valid_q, result_valid_d;
    logic                 overflow_q, overflow_d;
    logic                 bcd_err_q, bcd_err_d;
    logic                 ovf_sync;
    logic                 digit_err;

    sync_2ff u_ovf_sync (
        .clk (clk),
        .rst (rst),
        .d   (ovf_in),
        .q   (ovf_sync)
    );

    // NOTE: every flop is written with <= so all registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            gate_en_q      <= 1'b0;
            cnt_clear_q    <= 1'b1;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            bcd_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            gate_en_q      <= gate_en_d;
            cnt_clear_q    <= cnt_clear_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
            bcd_err_q      <= bcd_err_d;
        end
    end

    // NOTE: hold values are assigned first so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = GATE;
                    timer_d = GATE_LOAD;
                end
            end
            GATE: begin
                if (timer_q == '0) begin
                    state_d = SETTLE;
                    timer_d = SETTLE_LOAD;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    state_d = LATCH;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            LATCH: begin
                state_d = CLEAR;
                timer_d = CLEAR_LOAD;
            end
            CLEAR: begin
                if (timer_q == '0) begin
                    state_d = run ? GATE : IDLE;
                    timer_d = run ? GATE_LOAD : '0;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        digit_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > BCD_MAX) digit_err = 1'b1;
        end
    end

    // Decoding from the next state keeps gate_en/cnt_clear registered yet aligned with the state.
    always_comb begin
        gate_en_d      = (state_d == GATE);
        cnt_clear_d    = (state_d == IDLE) || (state_d == CLEAR);
        busy_d         = (state_d != IDLE);
        result_d       = result_q;
        overflow_d     = overflow_q;
        bcd_err_d      = bcd_err_q;
        result_valid_d = 1'b0;
        if (state_q == LATCH) begin
            result_d       = bcd_in;
            overflow_d     = ovf_sync;
            bcd_err_d      = digit_err;
            result_valid_d = 1'b1;
        end
    end

    assign gate_en      = gate_en_q;
    assign cnt_clear    = cnt_clear_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;
    assign bcd_err      = bcd_err_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl: cycle-counted gate/settle/clear phases plus a
// result scoreboard filled when count values are driven and drained on result_valid.
module tb_freq_gate_ctrl;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [W-1:0]  bcd_in;
    logic          ovf_in;
    logic          gate_en;
    logic          cnt_clear;
    logic          busy;
    logic [W-1:0]  result;
    logic          result_valid;
    logic          overflow;
    logic          bcd_err;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard entry: {bcd_err, overflow, result}
    logic [W+1:0] sb_q[$];

    freq_gate_ctrl #(
        .CLK_HZ     (1000),
        .GATE_MS    (10),
        .DIGITS     (DIGITS),
        .SETTLE_CYC (4),
        .CLEAR_CYC  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .bcd_in       (bcd_in),
        .ovf_in       (ovf_in),
        .gate_en      (gate_en),
        .cnt_clear    (cnt_clear),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .overflow     (overflow),
        .bcd_err      (bcd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic any_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        check("no_overlap", {31'd0, gate_en & cnt_clear}, 32'd0);
    endtask

    // One gate/settle/latch/clear sequence; keep_run=0 ends it in IDLE.
    task automatic measure(input logic [W-1:0] bcd, input logic ovf, input bit keep_run);
        int hi, lo, clr, wait_cyc;
        wait_cyc = 0;
        while (!gate_en && wait_cyc < 40) begin
            tick();
            wait_cyc++;
        end
        check("gate_start", {31'd0, gate_en}, 32'd1);
        if (!gate_en) return;
        check("busy_gate", {31'd0, busy}, 32'd1);
        bcd_in = bcd;
        ovf_in = ovf;
        sb_q.push_back({any_bad_digit(bcd), ovf, bcd});
        hi = 1;
        while (hi < 30) begin
            tick();
            if (gate_en) hi++;
            else break;
        end
        check("gate_len", hi, 10);
        lo = 0;
        while (!gate_en && !cnt_clear && lo < 30) begin
            lo++;
            tick();
        end
        check("settle_latch_len", lo, 5);
        check("busy_clear", {31'd0, busy}, 32'd1);
        if (!keep_run) begin
            run = 1'b0;
            for (int i = 0; i < 4; i++) begin
                check("clear_hold", {31'd0, cnt_clear}, 32'd1);
                tick();
            end
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_clear", {31'd0, cnt_clear}, 32'd1);
            check("idle_gate", {31'd0, gate_en}, 32'd0);
        end else begin
            clr = 0;
            while (cnt_clear && !gate_en && clr < 30) begin
                clr++;
                tick();
            end
            check("clear_len", clr, 4);
            check("regate", {31'd0, gate_en}, 32'd1);
        end
    endtask

    // Scoreboard drain: every result_valid cycle must match the oldest pending expectation.
    initial begin
        logic [W+1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp = sb_q.pop_front();
                    check("result", {16'd0, result}, {16'd0, exp[W-1:0]});
                    check("overflow", {31'd0, overflow}, {31'd0, exp[W]});
                    check("bcd_err", {31'd0, bcd_err}, {31'd0, exp[W+1]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        run    = 1'b0;
        bcd_in = '0;
        ovf_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("rst_gate", {31'd0, gate_en}, 32'd0);
        check("rst_clear", {31'd0, cnt_clear}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_err", {31'd0, bcd_err}, 32'd0);

        rst = 1'b0;
        run = 1'b1;
        measure(16'h1234, 1'b0, 1'b1);
        measure(16'h5678, 1'b1, 1'b1);
        measure(16'h12A4, 1'b0, 1'b1);
        measure(16'h0099, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) tick();
        check("hold_gate", {31'd0, gate_en}, 32'd0);
        check("hold_result", {16'd0, result}, 32'h0099);
        check("hold_valid", {31'd0, result_valid}, 32'd0);

        run = 1'b1;
        tick();
        run = 1'b0;
        measure(16'h0987, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        check("pulse_idle_gate", {31'd0, gate_en}, 32'd0);
        check("pulse_idle_busy", {31'd0, busy}, 32'd0);
        check("pulse_result", {16'd0, result}, 32'h0987);

        // Reset arriving on the fifth gate cycle aborts the measurement.
        run = 1'b1;
        tick();
        check("abort_gate_on", {31'd0, gate_en}, 32'd1);
        bcd_in = 16'h4321;
        ovf_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("abort_still_gate", {31'd0, gate_en}, 32'd1);
        rst = 1'b1;
        run = 1'b0;
        tick();
        check("abort_gate", {31'd0, gate_en}, 32'd0);
        check("abort_clear", {31'd0, cnt_clear}, 32'd1);
        check("abort_result", {16'd0, result}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, result_valid}, 32'd0);
        check("abort_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        ovf_in = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        check("abort_idle_gate", {31'd0, gate_en}, 32'd0);
        check("abort_idle_result", {16'd0, result}, 32'd0);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
